// File: rtl/rom_load_pkg.sv
// rom_load_pkg: shared types and constants for the ROM download controller.
//   state_t    : controller FSM states (also visible on rom_load_ctrl.fsm_state)
//   region_t   : 2-bit ROM region index
//   CS_R0..R3  : one-hot region selects driven on rom_cs
//   region_cs(): converts a region index to its one-hot select
package rom_load_pkg;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      LOADING = 3'd1,
      SETTLE  = 3'd2,
      RUN     = 3'd3,
      ERROR   = 3'd4
   } state_t;

   typedef logic [1:0] region_t;

   localparam logic [3:0]  CS_R0     = 4'b0001;
   localparam logic [3:0]  CS_R1     = 4'b0010;
   localparam logic [3:0]  CS_R2     = 4'b0100;
   localparam logic [3:0]  CS_R3     = 4'b1000;
   localparam logic [17:0] COUNT_MAX = 18'h3FFFF;

   function automatic logic [3:0] region_cs(input region_t r);
      logic [3:0] cs;
      case (r)
         2'd0:    cs = CS_R0;
         2'd1:    cs = CS_R1;
         2'd2:    cs = CS_R2;
         default: cs = CS_R3;
      endcase
      return cs;
   endfunction

endpackage

// File: rtl/rom_load_ctrl_decode.sv
// rom_region_decode: combinational split of an 18-bit image address into one
// of four ROM regions.
//   addr      : in  18, image byte address
//   r1_base   : in  18, first byte of region 1 (region 0 starts at 0)
//   r2_base   : in  18, first byte of region 2
//   r3_base   : in  18, first byte of region 3
//   total_len : in  18, image length; region 3 ends just below it
//   region    : out 2,  region index
//   offset    : out 18, addr minus the region base
//   in_range  : out 1,  addr < total_len
module rom_region_decode
   import rom_load_pkg::*;
(
   input  logic [17:0] addr,
   input  logic [17:0] r1_base,
   input  logic [17:0] r2_base,
   input  logic [17:0] r3_base,
   input  logic [17:0] total_len,
   output region_t     region,
   output logic [17:0] offset,
   output logic        in_range
);

   always_comb begin
      region   = 2'd0;
      offset   = addr;
      in_range = (addr < total_len);
      if (addr >= r3_base) begin
         region = 2'd3;
         offset = addr - r3_base;
      end else if (addr >= r2_base) begin
         region = 2'd2;
         offset = addr - r2_base;
      end else if (addr >= r1_base) begin
         region = 2'd1;
         offset = addr - r1_base;
      end
   end

endmodule

// File: rtl/rom_load_ctrl.sv
// rom_load_ctrl: sequences the HPS ROM download into the core. Decodes the
// byte stream into four regions, issues a registered one-cycle write strobe,
// holds the core in reset through the download plus a settle period, and
// latches an error when the image length or an address is wrong.
//   clk_sys        : in  1,  system clock
//   reset_n        : in  1,  asynchronous active-low reset
//   ioctl_download : in  1,  download in progress
//   ioctl_wr       : in  1,  byte strobe
//   ioctl_index    : in  16, image index
//   ioctl_addr     : in  25, absolute byte address
//   ioctl_dout     : in  8,  byte data
//   dn_addr        : out 18, region-local address
//   dn_data        : out 8,  registered byte
//   dn_wr          : out 1,  one-cycle write strobe
//   rom_cs         : out 4,  one-hot region select, valid with dn_wr
//   core_reset     : out 1,  active-high core reset (low only in RUN)
//   load_done      : out 1,  high in RUN
//   load_error     : out 1,  length/address error latched
//   byte_count     : out 18, accepted writes of current/last download
//   fsm_state      : out 3,  current controller state (state_t encoding)
// Handshake: ioctl_wr is a single-cycle strobe with no back-pressure; every
// accepted byte yields exactly one dn_wr pulse one cycle later.
module rom_load_ctrl
   import rom_load_pkg::*;
#(
   parameter logic [15:0] ROM_INDEX   = 16'd0,
   parameter logic [17:0] R1_BASE     = 18'h10000,
   parameter logic [17:0] R2_BASE     = 18'h18000,
   parameter logic [17:0] R3_BASE     = 18'h20000,
   parameter logic [17:0] TOTAL_LEN   = 18'h28000,
   parameter int unsigned HOLD_CYCLES = 4096
) (
   input  logic        clk_sys,
   input  logic        reset_n,
   input  logic        ioctl_download,
   input  logic        ioctl_wr,
   input  logic [15:0] ioctl_index,
   input  logic [24:0] ioctl_addr,
   input  logic [7:0]  ioctl_dout,
   output logic [17:0] dn_addr,
   output logic [7:0]  dn_data,
   output logic        dn_wr,
   output logic [3:0]  rom_cs,
   output logic        core_reset,
   output logic        load_done,
   output logic        load_error,
   output logic [17:0] byte_count,
   output logic [2:0]  fsm_state
);

   state_t      state, state_next;
   logic        dl_prev;
   logic        end_pend;
   logic        addr_err;
   logic [31:0] hold_cnt;

   region_t     dec_region;
   logic [17:0] dec_offset;
   logic        dec_in_range;

   logic idx_match, dl_start, wr_take, addr_ok, wr_ok, wr_bad;
   logic enter_loading;

   rom_region_decode u_decode (
      .addr      (ioctl_addr[17:0]),
      .r1_base   (R1_BASE),
      .r2_base   (R2_BASE),
      .r3_base   (R3_BASE),
      .total_len (TOTAL_LEN),
      .region    (dec_region),
      .offset    (dec_offset),
      .in_range  (dec_in_range)
   );

   assign idx_match = (ioctl_index == ROM_INDEX);
   // Starts are edge-based so a download interrupted by reset_n is ignored
   // until ioctl_download has gone low; dl_prev resets high for that reason.
   assign dl_start  = ioctl_download && !dl_prev && idx_match;
   // Writes are taken until the length check cycle, including the one that
   // coincides with ioctl_download falling.
   assign wr_take   = (state == LOADING) && !end_pend && ioctl_wr && idx_match;
   assign addr_ok   = (ioctl_addr[24:18] == 7'd0) && dec_in_range;
   assign wr_ok     = wr_take && addr_ok;
   assign wr_bad    = wr_take && !addr_ok;

   assign enter_loading = (state_next == LOADING) && (state != LOADING);
   assign fsm_state     = state;

   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (dl_start) state_next = LOADING;
         end
         LOADING: begin
            // end_pend marks the cycle after the download fell, so byte_count
            // already includes a write issued on the falling cycle.
            if (end_pend) begin
               if ((byte_count == TOTAL_LEN) && !addr_err) state_next = SETTLE;
               else                                        state_next = ERROR;
            end
         end
         SETTLE: begin
            if (dl_start)                               state_next = LOADING;
            else if (hold_cnt == 32'(HOLD_CYCLES - 1))  state_next = RUN;
         end
         RUN, ERROR: begin
            if (dl_start) state_next = LOADING;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         state      <= IDLE;
         dl_prev    <= 1'b1;
         end_pend   <= 1'b0;
         addr_err   <= 1'b0;
         hold_cnt   <= 32'd0;
         dn_addr    <= 18'd0;
         dn_data    <= 8'd0;
         dn_wr      <= 1'b0;
         rom_cs     <= 4'd0;
         core_reset <= 1'b1;
         load_done  <= 1'b0;
         load_error <= 1'b0;
         byte_count <= 18'd0;
      end else begin
         state    <= state_next;
         dl_prev  <= ioctl_download;
         end_pend <= (state == LOADING) && (state_next == LOADING) && !ioctl_download;
         hold_cnt <= (state == SETTLE) ? hold_cnt + 32'd1 : 32'd0;

         if (enter_loading)  addr_err <= 1'b0;
         else if (wr_bad)    addr_err <= 1'b1;

         if (enter_loading)                       byte_count <= 18'd0;
         else if (wr_ok && byte_count != COUNT_MAX) byte_count <= byte_count + 18'd1;

         if (enter_loading)                               load_error <= 1'b0;
         else if (state_next == ERROR && state != ERROR)  load_error <= 1'b1;

         core_reset <= (state_next != RUN);
         load_done  <= (state_next == RUN);

         dn_wr <= wr_ok;
         if (wr_ok) begin
            dn_addr <= dec_offset;
            dn_data <= ioctl_dout;
            rom_cs  <= region_cs(dec_region);
         end else begin
            rom_cs  <= 4'd0;
         end
      end
   end

endmodule

// File: tb/tb_rom_load_ctrl.sv
module tb_rom_load_ctrl;
  import rom_load_pkg::*;

  // Scaled-down image (region sizes divided by 256) keeps each download short.
  localparam logic [15:0] ROM_IDX = 16'd0;
  localparam logic [17:0] R1  = 18'h100;
  localparam logic [17:0] R2  = 18'h180;
  localparam logic [17:0] R3  = 18'h200;
  localparam logic [17:0] TOT = 18'h280;
  localparam int          HOLD = 64;

  logic        clk_sys = 1'b0;
  logic        reset_n = 1'b0;
  logic        ioctl_download = 1'b0;
  logic        ioctl_wr = 1'b0;
  logic [15:0] ioctl_index = 16'd0;
  logic [24:0] ioctl_addr = 25'd0;
  logic [7:0]  ioctl_dout = 8'd0;
  logic [17:0] dn_addr;
  logic [7:0]  dn_data;
  logic        dn_wr;
  logic [3:0]  rom_cs;
  logic        core_reset;
  logic        load_done;
  logic        load_error;
  logic [17:0] byte_count;
  logic [2:0]  fsm_state;

  logic [29:0] exp_q[$];
  int n_assert = 0;
  int n_fail = 0;

  // clock / reset
  always #5 clk_sys = ~clk_sys;

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish, assertions %0d failures %0d", n_assert, n_fail);
    $fatal(1, "timeout");
  end

  rom_load_ctrl #(
    .ROM_INDEX(ROM_IDX), .R1_BASE(R1), .R2_BASE(R2), .R3_BASE(R3),
    .TOTAL_LEN(TOT), .HOLD_CYCLES(HOLD)
  ) dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .ioctl_download(ioctl_download),
    .ioctl_wr(ioctl_wr), .ioctl_index(ioctl_index), .ioctl_addr(ioctl_addr),
    .ioctl_dout(ioctl_dout), .dn_addr(dn_addr), .dn_data(dn_data), .dn_wr(dn_wr),
    .rom_cs(rom_cs), .core_reset(core_reset), .load_done(load_done),
    .load_error(load_error), .byte_count(byte_count), .fsm_state(fsm_state)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model of the region split: {rom_cs, dn_addr, dn_data}.
  function automatic logic [29:0] model(input logic [17:0] a, input logic [7:0] d);
    logic [3:0]  cs;
    logic [17:0] off;
    if (a < R1)      begin cs = 4'b0001; off = a;      end
    else if (a < R2) begin cs = 4'b0010; off = a - R1; end
    else if (a < R3) begin cs = 4'b0100; off = a - R2; end
    else             begin cs = 4'b1000; off = a - R3; end
    return {cs, off, d};
  endfunction

  // scoreboard: every dn_wr must match the oldest expected write
  always @(negedge clk_sys) begin
    if (dn_wr === 1'b1) begin
      if (exp_q.size() == 0) check("dn_wr_unexpected", 32'(dn_wr), 32'd0);
      else check("dn_write", {2'b00, rom_cs, dn_addr, dn_data}, {2'b00, exp_q.pop_front()});
    end
  end

  task automatic check_reset_vals(input string tag);
    check({tag, "_dn_wr"}, 32'(dn_wr), 32'd0);
    check({tag, "_rom_cs"}, 32'(rom_cs), 32'd0);
    check({tag, "_dn_addr"}, 32'(dn_addr), 32'd0);
    check({tag, "_dn_data"}, 32'(dn_data), 32'd0);
    check({tag, "_core_reset"}, 32'(core_reset), 32'd1);
    check({tag, "_load_done"}, 32'(load_done), 32'd0);
    check({tag, "_load_error"}, 32'(load_error), 32'd0);
    check({tag, "_byte_count"}, 32'(byte_count), 32'd0);
    check({tag, "_state"}, 32'(fsm_state), 32'(IDLE));
  endtask

  // driver: n sequential bytes from address 0, last byte on the falling
  // download cycle; bad_at inserts two out-of-range writes; rst_at pulses reset_n
  task automatic download(input logic [15:0] idx, input int n, input int bad_at, input int rst_at);
    logic accept;
    accept = (idx == ROM_IDX);
    @(negedge clk_sys);
    ioctl_index = idx;
    ioctl_download = 1'b1;
    for (int i = 0; i < n; i++) begin
      @(negedge clk_sys);
      if (i == rst_at) begin
        ioctl_wr = 1'b0;
        #2 reset_n = 1'b0;
        #1 check_reset_vals("mid_reset");
        exp_q.delete();
        accept = 1'b0;
        @(negedge clk_sys);
        reset_n = 1'b1;
      end
      if (i == bad_at) begin
        ioctl_wr = 1'b1;
        ioctl_addr = 25'(TOT);
        ioctl_dout = 8'hEE;
        @(negedge clk_sys);
        ioctl_addr = 25'h40000;
        @(negedge clk_sys);
      end
      ioctl_wr = 1'b1;
      ioctl_addr = 25'(i);
      ioctl_dout = 8'($urandom_range(0, 255));
      if (i == n - 1) ioctl_download = 1'b0;
      if (accept) exp_q.push_back(model(18'(i), ioctl_dout));
    end
    @(negedge clk_sys);
    ioctl_wr = 1'b0;
    ioctl_download = 1'b0;
  endtask

  task automatic expect_run(input string tag);
    int settle;
    int budget;
    int cr_low;
    settle = 0;
    budget = 0;
    cr_low = 0;
    while (fsm_state !== 3'(RUN) && budget < 1000) begin
      @(negedge clk_sys);
      budget++;
      if (fsm_state === 3'(SETTLE)) begin
        settle++;
        if (core_reset !== 1'b1) cr_low++;
      end
    end
    check({tag, "_reached_run"}, 32'(fsm_state), 32'(RUN));
    check({tag, "_settle_cycles"}, 32'(settle), 32'(HOLD));
    check({tag, "_core_reset_in_settle"}, 32'(cr_low), 32'd0);
    check({tag, "_core_reset"}, 32'(core_reset), 32'd0);
    check({tag, "_load_done"}, 32'(load_done), 32'd1);
    check({tag, "_load_error"}, 32'(load_error), 32'd0);
    check({tag, "_byte_count"}, 32'(byte_count), 32'(TOT));
    check({tag, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic expect_error(input string tag, input logic [17:0] count);
    repeat (3) @(negedge clk_sys);
    check({tag, "_state"}, 32'(fsm_state), 32'(ERROR));
    check({tag, "_load_error"}, 32'(load_error), 32'd1);
    check({tag, "_core_reset"}, 32'(core_reset), 32'd1);
    check({tag, "_load_done"}, 32'(load_done), 32'd0);
    check({tag, "_byte_count"}, 32'(byte_count), 32'(count));
    check({tag, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    // reset state
    repeat (3) @(negedge clk_sys);
    check_reset_vals("por");
    reset_n = 1'b1;

    // idle with no download
    repeat (20) @(negedge clk_sys);
    check("idle_core_reset", 32'(core_reset), 32'd1);
    check("idle_load_done", 32'(load_done), 32'd0);
    check("idle_state", 32'(fsm_state), 32'(IDLE));

    // full good download
    download(ROM_IDX, int'(TOT), -1, -1);
    expect_run("good1");

    // short download, then a good one clears the error
    download(ROM_IDX, int'(TOT) - 1, -1, -1);
    expect_error("short", TOT - 18'd1);
    download(ROM_IDX, int'(TOT), -1, -1);
    expect_run("good2");

    // out-of-range writes inside a complete download
    download(ROM_IDX, int'(TOT), 300, -1);
    expect_error("badaddr", TOT);

    // foreign index from ERROR: nothing changes
    download(16'd1, 40, -1, -1);
    repeat (3) @(negedge clk_sys);
    check("idx1_err_state", 32'(fsm_state), 32'(ERROR));
    check("idx1_err_load_error", 32'(load_error), 32'd1);
    check("idx1_err_byte_count", 32'(byte_count), 32'(TOT));

    // reset_n pulsed mid-download; remainder ignored
    download(ROM_IDX, int'(TOT), -1, 'h80);
    repeat (3) @(negedge clk_sys);
    check("post_reset_state", 32'(fsm_state), 32'(IDLE));
    check("post_reset_byte_count", 32'(byte_count), 32'd0);
    check("post_reset_core_reset", 32'(core_reset), 32'd1);
    download(ROM_IDX, int'(TOT), -1, -1);
    expect_run("good3");

    // foreign index from RUN: core keeps running
    download(16'd1, 40, -1, -1);
    repeat (3) @(negedge clk_sys);
    check("idx1_run_state", 32'(fsm_state), 32'(RUN));
    check("idx1_run_load_done", 32'(load_done), 32'd1);
    check("idx1_run_core_reset", 32'(core_reset), 32'd0);
    check("final_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
